// File: rtl/pipe_decode_writeback.sv
// rtl/pipe_decode_writeback.sv - Y86-64 PIPE register file, operand forwarding and D->E pipeline register
module pipe_decode_writeback #(
    parameter int                 DATA_W    = 64,
    parameter int                 NREGS     = 15,
    parameter int                 RID_W     = 4,
    parameter int                 RSP_ID    = 4,
    parameter logic [DATA_W-1:0]  RSP_RESET = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RID_W-1:0]        d_srcA,
    input  logic [RID_W-1:0]        d_srcB,
    input  logic                    d_sel_valP,
    input  logic [DATA_W-1:0]       d_valP,
    input  logic [RID_W-1:0]        e_dstE,
    input  logic [DATA_W-1:0]       e_valE,
    input  logic [RID_W-1:0]        M_dstM,
    input  logic [DATA_W-1:0]       m_valM,
    input  logic [RID_W-1:0]        M_dstE,
    input  logic [DATA_W-1:0]       M_valE,
    input  logic [RID_W-1:0]        W_dstM,
    input  logic [DATA_W-1:0]       W_valM,
    input  logic [RID_W-1:0]        W_dstE,
    input  logic [DATA_W-1:0]       W_valE,
    input  logic                    E_stall,
    input  logic                    E_bubble,
    output logic [DATA_W-1:0]       d_valA,
    output logic [DATA_W-1:0]       d_valB,
    output logic [DATA_W-1:0]       E_valA,
    output logic [DATA_W-1:0]       E_valB,
    output logic [RID_W-1:0]        E_srcA,
    output logic [RID_W-1:0]        E_srcB,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    localparam logic [RID_W-1:0] RNONE = '1;

    logic [DATA_W-1:0] regs [NREGS];

    // Architectural file; the M port is written last so it wins a same-ID conflict.
    // IDs outside 0..NREGS-1 (including RNONE) match no entry and write nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == RSP_ID) ? RSP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (W_dstE == RID_W'(i)) regs[i] <= W_valE;
                if (W_dstM == RID_W'(i)) regs[i] <= W_valM;
            end
        end
    end

    // Youngest producer first; an RNONE source never matches, which also
    // keeps an RNONE destination from ever matching.
    function automatic logic [DATA_W-1:0] resolve(input logic [RID_W-1:0] src);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src == RID_W'(i)) val = regs[i];
        end
        if (src != RNONE) begin
            if      (src == e_dstE) val = e_valE;
            else if (src == M_dstM) val = m_valM;
            else if (src == M_dstE) val = M_valE;
            else if (src == W_dstM) val = W_valM;
            else if (src == W_dstE) val = W_valE;
        end
        return val;
    endfunction

    // Combinational operand selection; valP overrides the A path for call/jXX.
    always_comb begin
        d_valA = resolve(d_srcA);
        d_valB = resolve(d_srcB);
        if (d_sel_valP) d_valA = d_valP;
    end

    // E-stage register: stall holds and beats bubble, bubble inserts a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_valA <= '0;
            E_valB <= '0;
            E_srcA <= RNONE;
            E_srcB <= RNONE;
        end else if (E_stall) begin
            E_valA <= E_valA;
            E_valB <= E_valB;
            E_srcA <= E_srcA;
            E_srcB <= E_srcB;
        end else if (E_bubble) begin
            E_valA <= '0;
            E_valB <= '0;
            E_srcA <= RNONE;
            E_srcB <= RNONE;
        end else begin
            E_valA <= d_valA;
            E_valB <= d_valB;
            E_srcA <= d_srcA;
            E_srcB <= d_srcB;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
        end
    endgenerate

endmodule
